// File: rtl/ld_cmd_tx_pkg.sv
// Shared radar UART link definitions: frame header bytes, payload limit and frame-state encoding.
// The receiver's frame parser uses the same constants.
package ld_cmd_tx_pkg;

   localparam logic [7:0]  LD_HDR0    = 8'h55;
   localparam logic [7:0]  LD_HDR1    = 8'hAA;
   localparam int unsigned LD_MAX_PAY = 4;

   typedef enum logic [2:0] {
      StIdle,
      StHdr0,
      StHdr1,
      StCmd,
      StLen,
      StPay,
      StCsum
   } ld_frame_state_e;

   function automatic logic [2:0] ld_clamp_len(input logic [2:0] len);
      return (len > 3'(LD_MAX_PAY)) ? 3'(LD_MAX_PAY) : len;
   endfunction

endpackage

// File: rtl/ld_cmd_tx_byte.sv
// 8N1 UART byte serializer. A load during the last cycle of a stop bit chains the next byte
// with no idle time.
module uart_byte_tx #(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [7:0] i_data,
   output logic       o_txd,
   output logic       o_busy,
   output logic       o_byte_done
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_baud_cnt;
   logic [3:0]    r_bit_cnt;
   logic [7:0]    r_data;
   logic          r_txd;
   logic          r_busy;
   logic          w_bit_end;

   assign w_bit_end   = (r_baud_cnt == BAUD_MAX);
   // Bit 9 is the stop bit; its final cycle is where the next byte may be loaded.
   assign o_byte_done = r_busy && w_bit_end && (r_bit_cnt == 4'd9);
   assign o_txd       = r_txd;
   assign o_busy      = r_busy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_data     <= '0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
      end else if (i_load && (!r_busy || o_byte_done)) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_data     <= i_data;
         r_txd      <= 1'b0;
         r_busy     <= 1'b1;
      end else if (r_busy) begin
         if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
               r_bit_cnt <= '0;
               r_txd     <= 1'b1;
               r_busy    <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
               r_txd     <= (r_bit_cnt == 4'd8) ? 1'b1 : r_data[r_bit_cnt[2:0]];
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ld_cmd_tx.sv
// Radar command-frame transmitter: 55 AA CMD LEN P0..Pn CSUM as back-to-back 8N1 bytes.
// Holds the frame FSM, latched request fields and the running checksum.
module ld_cmd_tx
   import ld_cmd_tx_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic        i_start,
   input  logic [7:0]  i_cmd,
   input  logic [2:0]  i_len,
   input  logic [31:0] i_payload,
   output logic        o_uart_txd,
   output logic        o_busy,
   output logic        o_done
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

   ld_frame_state_e r_state, w_state_next;
   logic [7:0]      r_cmd;
   logic [2:0]      r_len;
   logic [31:0]     r_pay, w_pay_next;
   logic [2:0]      r_pay_cnt, w_pay_cnt_next;
   logic [7:0]      r_csum, w_csum_next;
   logic            r_busy;
   logic            r_done;
   logic            w_load;
   logic [7:0]      w_load_data;
   logic            w_byte_done;
   logic            w_ser_busy;
   logic            w_accept;

   assign w_accept = i_start && (r_state == StIdle) && !w_ser_busy;

   always_comb begin
      w_state_next   = r_state;
      w_pay_next     = r_pay;
      w_pay_cnt_next = r_pay_cnt;
      w_csum_next    = r_csum;
      w_load         = 1'b0;
      w_load_data    = 8'h00;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_load         = 1'b1;
               w_load_data    = LD_HDR0;
               w_state_next   = StHdr0;
               w_pay_next     = i_payload;
               w_pay_cnt_next = ld_clamp_len(i_len);
               w_csum_next    = 8'h00;
            end
         end
         StHdr0: begin
            if (w_byte_done) begin
               w_load       = 1'b1;
               w_load_data  = LD_HDR1;
               w_state_next = StHdr1;
            end
         end
         StHdr1: begin
            if (w_byte_done) begin
               w_load       = 1'b1;
               w_load_data  = r_cmd;
               w_csum_next  = r_csum + r_cmd;
               w_state_next = StCmd;
            end
         end
         StCmd: begin
            if (w_byte_done) begin
               w_load       = 1'b1;
               w_load_data  = {5'b0, r_len};
               w_csum_next  = r_csum + {5'b0, r_len};
               w_state_next = StLen;
            end
         end
         StLen, StPay: begin
            if (w_byte_done) begin
               w_load = 1'b1;
               if (r_pay_cnt == 3'd0) begin
                  w_load_data  = r_csum;
                  w_state_next = StCsum;
               end else begin
                  // Payload goes out LSB byte first; shift the latch down per byte.
                  w_load_data    = r_pay[7:0];
                  w_csum_next    = r_csum + r_pay[7:0];
                  w_pay_next     = r_pay >> 8;
                  w_pay_cnt_next = r_pay_cnt - 3'd1;
                  w_state_next   = StPay;
               end
            end
         end
         StCsum: begin
            if (w_byte_done) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state   <= StIdle;
         r_cmd     <= '0;
         r_len     <= '0;
         r_pay     <= '0;
         r_pay_cnt <= '0;
         r_csum    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_pay     <= w_pay_next;
         r_pay_cnt <= w_pay_cnt_next;
         r_csum    <= w_csum_next;
         r_busy    <= (w_state_next != StIdle);
         r_done    <= (r_state == StCsum) && w_byte_done;
         if (w_accept) begin
            r_cmd <= i_cmd;
            r_len <= ld_clamp_len(i_len);
         end
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .i_clk      (i_sys_clk),
      .i_rst      (i_sys_rst),
      .i_load     (w_load),
      .i_data     (w_load_data),
      .o_txd      (o_uart_txd),
      .o_busy     (w_ser_busy),
      .o_byte_done(w_byte_done)
   );

endmodule

// File: tb/tb_ld_cmd_tx.sv
// Scoreboard bench for ld_cmd_tx: a UART line decoder and a done-timing monitor pop expected
// bytes and frame lengths pushed by the stimulus process.
module tb_ld_cmd_tx;

   localparam int unsigned CLK_FREQ = 1_000_000;
   localparam int unsigned BAUD     = 100_000;
   localparam int unsigned CPB      = CLK_FREQ / BAUD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  cmd = 8'h00;
   logic [2:0]  len = 3'd0;
   logic [31:0] pay = 32'h0;
   logic        txd;
   logic        busy;
   logic        done;

   typedef struct {
      logic [7:0] b;
      bit         first;
   } exp_byte_t;

   exp_byte_t   exp_q[$];
   int unsigned len_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   ld_cmd_tx #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst),
      .i_start   (start),
      .i_cmd     (cmd),
      .i_len     (len),
      .i_payload (pay),
      .o_uart_txd(txd),
      .o_busy    (busy),
      .o_done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // UART line decoder: samples each bit at its middle and scores the byte.
   bit         dec_active = 0;
   int         dec_cnt = 0;
   int         dec_start = 0;
   int         last_start = 0;
   logic [7:0] dec_shift = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         dec_active = 0;
         exp_q.delete();
      end else if (!dec_active) begin
         if (txd == 1'b0) begin
            dec_active = 1;
            dec_cnt    = 0;
            dec_start  = cyc;
         end
      end else begin
         dec_cnt++;
         if ((dec_cnt % CPB) == CPB / 2) begin
            int bitn;
            bitn = dec_cnt / CPB;
            if (bitn == 0) begin
               check("start_bit", 32'(txd), 32'd0);
            end else if (bitn <= 8) begin
               dec_shift[bitn-1] = txd;
            end else begin
               exp_byte_t e;
               check("stop_bit", 32'(txd), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_byte: got %0h expected none", dec_shift);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_byte", 32'(dec_shift), 32'(e.b));
                  if (!e.first) check("byte_gap", 32'(dec_start - last_start), 32'(10 * CPB));
               end
               last_start = dec_start;
               dec_active = 0;
            end
         end
      end
   end

   // Done monitor: frame length measured from o_busy rising to the o_done cycle.
   bit busy_prev = 0;
   int busy_start = 0;

   always @(negedge clk) begin
      if (rst) begin
         busy_prev = 0;
         len_q.delete();
      end else begin
         if (busy && !busy_prev) busy_start = cyc;
         if (done) begin
            if (len_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got 1 expected 0");
            end else begin
               check("frame_cycles", 32'(cyc - busy_start), 32'(len_q.pop_front()));
            end
            check("done_busy", 32'(busy), 32'd0);
            check("done_txd", 32'(txd), 32'd1);
         end
         busy_prev = busy;
      end
   end

   // Reference model: builds the byte list and frame length from the frame rules.
   task automatic issue(input logic [7:0] c, input logic [2:0] l, input logic [31:0] p);
      int n;
      int sum;
      exp_byte_t e;
      n = (l > 3'd4) ? 4 : int'(l);
      sum = int'(c) + n;
      e.first = 1; e.b = 8'h55; exp_q.push_back(e);
      e.first = 0; e.b = 8'hAA; exp_q.push_back(e);
      e.b = c; exp_q.push_back(e);
      e.b = 8'(n); exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         e.b = 8'((p >> (8 * i)) & 32'hFF);
         sum += int'(e.b);
         exp_q.push_back(e);
      end
      e.b = 8'(sum % 256); exp_q.push_back(e);
      len_q.push_back(10 * (5 + n) * CPB);
      start = 1'b1; cmd = c; len = l; pay = p;
      @(negedge clk);
      start = 1'b0; cmd = 8'($urandom); len = 3'($urandom); pay = $urandom;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(8'h01, 3'd0, 32'h0);
      wait_idle(); repeat (3) @(negedge clk);
      issue(8'hA2, 3'd2, 32'h0000_1234);
      wait_idle(); repeat (3) @(negedge clk);
      issue(8'hFF, 3'd4, 32'hFFFF_FFFF);
      wait_idle(); repeat (3) @(negedge clk);
      issue(8'h10, 3'd7, 32'h0403_0201);
      wait_idle(); repeat (3) @(negedge clk);

      // Mid-frame start is ignored; a start in the done cycle chains immediately.
      issue(8'h5A, 3'd3, $urandom);
      repeat (50) @(negedge clk);
      start = 1'b1; cmd = 8'h99; len = 3'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      issue(8'h3C, 3'd1, $urandom);
      check("b2b_txd", 32'(txd), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         issue(8'($urandom), 3'($urandom), $urandom);
         wait_idle();
      end

      // Reset during payload, together with a start request.
      repeat (2) @(negedge clk);
      issue(8'h77, 3'd4, $urandom);
      repeat (45 * CPB) @(negedge clk);
      rst = 1'b1; start = 1'b1; cmd = 8'h11; len = 3'd2;
      @(negedge clk);
      check("abort_txd", 32'(txd), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      repeat (100 * CPB) @(negedge clk);
      issue(8'h42, 3'd4, $urandom);
      wait_idle();

      repeat (5) @(negedge clk);
      check("bytes_left", 32'(exp_q.size()), 32'd0);
      check("frames_left", 32'(len_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
